// File: rtl/fetch_pkg.sv
// Shared types and default constants for the TinyCPU fetch sequencer.
package fetch_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_INSTR_W = 16;
  localparam logic [3:0] DEF_HALT_OP = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0]  pc;
    logic [DEF_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Pointer-based FIFO of fetch entries with synchronous flush and async reset.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  fetch_entry_t               push_entry,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t       mem_q [DEPTH];
  fetch_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Flush wins over push/pop; the caller never pushes when full without a pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// TinyCPU fetch sequencer: PC, start/halt FSM, redirect and fetch queue.
// Optional FETCH_PERF_EN adds saturating perf_fetched/perf_stall counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter int                QDEPTH   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HALT_OP  = DEF_HALT_OP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt_req,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
`ifdef FETCH_PERF_EN
  output logic [15:0]        perf_fetched,
  output logic [15:0]        perf_stall,
`endif
  output logic               halted
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               push, pop, flush, has_room;
  logic [CNT_W-1:0]   count;
  fetch_entry_t       push_entry, head;

  assign pop        = out_valid && out_ready && !redirect_valid;
  assign has_room   = (count < CNT_W'(QDEPTH)) || pop;
  assign push_entry = '{pc: pc_q, instr: imem_instr};

  // Priority: redirect > halt_req > HALT opcode > normal fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      flush = 1'b1;
      pc_d  = redirect_pc;
      if (start) state_d = RUN;
    end else begin
      unique case (state_q)
        IDLE, HALTED: if (start) state_d = RUN;
        RUN: begin
          if (halt_req) begin
            state_d = HALTED;
          end else if (has_room) begin
            push = 1'b1;
            if (imem_instr[INSTR_W-1 -: 4] == HALT_OP) begin
              state_d = HALTED;
            end else begin
              pc_d = pc_q + ADDR_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push       (push),
    .pop        (pop),
    .push_entry (push_entry),
    .head       (head),
    .count      (count)
  );

  assign imem_addr = pc_q;
  assign out_valid = (count != '0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign halted    = (state_q == HALTED) && (count == '0);

`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched_q, perf_fetched_d;
  logic [15:0] perf_stall_q, perf_stall_d;
  logic        stall;

  assign stall = (state_q == RUN) && (count == CNT_W'(QDEPTH)) && !pop && !redirect_valid;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    if (push && perf_fetched_q != 16'hFFFF) perf_fetched_d = perf_fetched_q + 16'd1;
    if (stall && perf_stall_q != 16'hFFFF)  perf_stall_d   = perf_stall_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational ROM model of program.hex.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        halt_req;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic [7:0]  imem_addr;
  logic [15:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [7:0]  out_pc;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_stall;
`endif

  logic [15:0] rom [256];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_instr = rom[imem_addr];

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
`ifdef FETCH_PERF_EN
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
`endif
    .halted         (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic head(input string tag, input logic [7:0] pc, input logic [15:0] instr);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_pc"},    32'(out_pc),    32'(pc));
    chk({tag, "_instr"}, 32'(out_instr), 32'(instr));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[0] = 16'h1122; rom[1] = 16'h3344; rom[2] = 16'hDEAD;
    rom[3] = 16'hBEEF; rom[4] = 16'h5566; rom[5] = 16'hF000;

    rst = 1'b1; start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 8'h00; out_ready = 1'b0;
    cyc(2);
    chk("rst_valid",  32'(out_valid), 32'd0);
    chk("rst_instr",  32'(out_instr), 32'd0);
    chk("rst_pc",     32'(out_pc),    32'd0);
    chk("rst_halted", 32'(halted),    32'd0);
    chk("rst_addr",   32'(imem_addr), 32'd0);
    rst = 1'b0;
    cyc(2);
    chk("idle_nofetch", 32'(out_valid), 32'd0);

    // 1: streaming with out_ready high, then run into HALT at addr5
    start = 1'b1; out_ready = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("t1_lat_valid", 32'(out_valid), 32'd0);
    cyc(1); head("t1_pc0", 8'h00, 16'h1122);
    cyc(1); head("t1_pc1", 8'h01, 16'h3344);
    cyc(1); head("t1_pc2", 8'h02, 16'hDEAD);
    cyc(1); head("t1_pc3", 8'h03, 16'hBEEF);
    cyc(1); head("t1_pc4", 8'h04, 16'h5566);
    cyc(1); head("t4_halt", 8'h05, 16'hF000);
    chk("t4_addr_hold", 32'(imem_addr), 32'h05);
    chk("t4_not_drained", 32'(halted), 32'd0);
    cyc(1);
    chk("t4_drained_valid", 32'(out_valid), 32'd0);
    chk("t4_halted", 32'(halted), 32'd1);
    cyc(1);
    chk("t4_addr_still5", 32'(imem_addr), 32'h05);
    start = 1'b1; out_ready = 1'b0;
    cyc(1);
    start = 1'b0;
    chk("t4_restart_halted", 32'(halted), 32'd0);
    cyc(1); head("t4_refetch", 8'h05, 16'hF000);
    out_ready = 1'b1;
    cyc(1);
    chk("t4_halted_again", 32'(halted), 32'd1);

    // 2: backpressure fills the queue; start+redirect from HALTED
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h00; start = 1'b1;
    cyc(1);
    redirect_valid = 1'b0; start = 1'b0;
    chk("t2_flush_valid", 32'(out_valid), 32'd0);
    chk("t2_addr0", 32'(imem_addr), 32'h00);
    cyc(3);
    head("t2_full_head", 8'h00, 16'h1122);
    chk("t2_addr_frozen", 32'(imem_addr), 32'h02);
    out_ready = 1'b1;
    cyc(1); head("t2_rel_pc1", 8'h01, 16'h3344);
    cyc(1); head("t2_rel_pc2", 8'h02, 16'hDEAD);

    // 3: redirect to 3 while full; no stale entry popped
    out_ready = 1'b0;
    cyc(1);
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h03;
    cyc(1);
    redirect_valid = 1'b0; out_ready = 1'b0;
    chk("t3_flush_valid", 32'(out_valid), 32'd0);
    chk("t3_addr", 32'(imem_addr), 32'h03);
    cyc(1); head("t3_target", 8'h03, 16'hBEEF);

    // 5: wrap-around from 8'hFF
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'hFF;
    cyc(1);
    redirect_valid = 1'b0;
    chk("t5_flush_valid", 32'(out_valid), 32'd0);
    cyc(1); head("t5_ff", 8'hFF, 16'h0000);
    cyc(1); head("t5_wrap", 8'h00, 16'h1122);

    // 6: async reset with queue non-empty
    out_ready = 1'b0;
    cyc(1);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_valid", 32'(out_valid), 32'd0);
    chk("t6_async_addr",  32'(imem_addr), 32'h00);
    chk("t6_async_pc",    32'(out_pc),    32'h00);
    cyc(1);
    rst = 1'b0;
    cyc(2);
    chk("t6_idle_valid", 32'(out_valid), 32'd0);
    chk("t6_idle_addr",  32'(imem_addr), 32'h00);

    // halt_req in RUN: stops fetch and holds PC
    start = 1'b1; out_ready = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1); head("hr_pc0", 8'h00, 16'h1122);
    halt_req = 1'b1;
    cyc(1);
    halt_req = 1'b0;
    chk("hr_valid", 32'(out_valid), 32'd0);
    chk("hr_addr",  32'(imem_addr), 32'h01);
    chk("hr_halted", 32'(halted),   32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch sequencer for TinyCPU. It owns the program counter and drives the address of the combinational inst_mem ROM, which has an 8-bit address and returns a 16-bit instruction in the same cycle. Each fetched instruction is paired with its PC, buffered in a small flushable queue, and handed to decode over a valid/ready handshake. The block also handles start, halt request, the HALT opcode and branch redirects.

Parameters:
ADDR_W, 8, PC and inst_mem address width
INSTR_W, 16, instruction width
QDEPTH, 2, fetch queue entries; must be a power of 2 and at least 2
RESET_PC, 8'h00, PC value loaded on reset
HALT_OP, 4'hF, value of instr[15:12] that marks a HALT instruction

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  pulse; moves IDLE or HALTED to RUN
halt_req  in  1  external stop request; RUN to HALTED
redirect_valid  in  1  branch/jump redirect strobe
redirect_pc  in  ADDR_W  redirect target address
imem_addr  out  ADDR_W  inst_mem address; equals pc_q (registered, no combinational input path)
imem_instr  in  INSTR_W  inst_mem read data
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts the head entry
out_instr  out  INSTR_W  head instruction
out_pc  out  ADDR_W  head PC
halted  out  1  high when state is HALTED and the queue is empty

Behaviour:
- Reset (asynchronous, any time including mid-fetch):
  - state=IDLE, pc_q=RESET_PC, queue count=0.
  - out_valid=0, out_instr=0, out_pc=0, halted=0, imem_addr=RESET_PC.
- States:
  - IDLE: no fetch. start goes to RUN.
  - RUN: fetch every cycle the push condition holds.
  - HALTED: no fetch; the queue keeps draining. start goes to RUN.
- push = (state==RUN) && !redirect_valid && (count<QDEPTH || pop).
  - On push, the entry {pc_q, imem_instr} enters the queue tail and pc_q <= pc_q+1, modulo 2^ADDR_W (8'hFF wraps to 8'h00).
- pop = out_valid && out_ready && !redirect_valid. Push and pop in the same cycle leave count unchanged; this is legal when full.
- Latency: start at edge E0; first entry pushed at E1; out_valid=1 after E1 with out_pc=pc_q.
- Back-to-back: with out_ready held high, one instruction per cycle and no bubbles.
- Redirect: highest priority after reset.
  - At the edge it is sampled: count<=0, pc_q<=redirect_pc; no push and no pop that cycle.
  - State is unchanged, except that in HALTED the PC is still updated.
  - The target instruction becomes valid one cycle later if in RUN.
- halt_req in RUN (no redirect): no push that cycle; go to HALTED; pc_q holds.
- HALT opcode: when a push occurs with imem_instr[15:12]==HALT_OP:
  - the HALT instruction itself is pushed;
  - pc_q holds at the HALT address (not incremented);
  - state goes to HALTED.
- Priority: rst > redirect_valid > halt_req > HALT opcode > normal fetch.
- start while in RUN is ignored. start together with redirect: both take effect (state=RUN, queue flushed, pc_q=target).
- out_* are driven from the registered queue head. When the queue is empty, out_instr/out_pc hold the last value and are don't-care.
- Queue: pointer-based; occupancy counter is clog2(QDEPTH)+1 bits wide; overflow and underflow cannot occur by construction.

Optional Feature:
FETCH_PERF_EN
- Defined: adds output ports perf_fetched[15:0] and perf_stall[15:0], both reset to 0 and both saturating at 16'hFFFF.
  - perf_fetched increments on every push.
  - perf_stall increments each RUN cycle with count==QDEPTH, no pop and no redirect.
- Undefined: these ports and their logic are absent; no other behaviour changes.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum {IDLE, RUN, HALTED};
  - HALT_OP and the default ADDR_W/INSTR_W constants;
  - the queue entry struct {pc, instr}.
- One sub-module: fetch_queue, a parameterised FIFO with a synchronous flush input and asynchronous reset, storing fetch_pkg entries.
- fetch_unit keeps the FSM, PC and push/pop logic.

Test Plan:
All scenarios use the standard program.hex: addr0=1122, addr2=DEAD, addr3=BEEF, HALT (F000) placed at addr5.
1. Start with out_ready=1 -> out_pc 0,1,2,3 on consecutive cycles; out_instr 1122, (addr1 value), DEAD, BEEF.
2. Hold out_ready=0 after start -> queue fills (2 entries), imem_addr frozen at 2. Release -> entries pc0/pc1 delivered, then pc2=DEAD with no entry lost or duplicated.
3. Redirect to 8'h03 while the queue is full -> next cycle out_valid=0. Following cycle out_pc=3, out_instr=BEEF; old entries are never popped.
4. Run to addr5 (F000) -> F000 is delivered, fetching stops, imem_addr stays 5, and halted=1 once drained. Then start -> the HALT instruction is refetched.
5. Redirect to 8'hFF with all-zero (non-HALT) content there -> out_pc 8'hFF followed by 8'h00 (wrap-around).
6. Assert rst mid-stream with the queue non-empty -> out_valid=0 immediately (asynchronously), imem_addr=0, state IDLE; no fetch until start.
